// File: rtl/pr_fifo_axis_reader_if.sv
// FIFO read port and AXI4-Stream master bundle used by pr_fifo_axis_reader.
// The master modport is the reader's view; the slave modport is the FIFO/consumer side.
interface pr_fifo_axis_reader_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] m_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tlast;
  logic                  m_axis_tready;

  modport master (
    input  fifo_dout,
    input  fifo_empty,
    input  m_axis_tready,
    output fifo_rd_en,
    output m_axis_tdata,
    output m_axis_tvalid,
    output m_axis_tlast
  );

  modport slave (
    output fifo_dout,
    output fifo_empty,
    output m_axis_tready,
    input  fifo_rd_en,
    input  m_axis_tdata,
    input  m_axis_tvalid,
    input  m_axis_tlast
  );
endinterface

// File: rtl/pr_fifo_axis_reader.sv
// Drains exactly `length` words from an FWFT FIFO into an AXI4-Stream burst
// through a single registered output stage, marking the final word with TLAST.
module pr_fifo_axis_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [LEN_WIDTH-1:0]   length,
  output logic                   busy,
  output logic                   done,
  output logic [LEN_WIDTH-1:0]   sent_count,
  pr_fifo_axis_reader_if.master  bus
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_e;

  localparam logic [LEN_WIDTH-1:0] LEN_ZERO = {LEN_WIDTH{1'b0}};
  localparam logic [LEN_WIDTH-1:0] LEN_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

  state_e                  state_q,      state_d;
  logic [LEN_WIDTH-1:0]    remaining_q,  remaining_d;
  logic [LEN_WIDTH-1:0]    sent_count_q, sent_count_d;
  logic                    done_q,       done_d;
  logic [DATA_WIDTH-1:0]   tdata_q,      tdata_d;
  logic                    tvalid_q,     tvalid_d;
  logic                    tlast_q,      tlast_d;

  logic                    load_s;
  logic                    hs_s;

  // Pop when streaming, words are still owed, the FIFO has one, and the output slot frees up.
  always_comb begin
    hs_s   = tvalid_q && bus.m_axis_tready;
    load_s = (state_q == ST_STREAM) && (remaining_q != LEN_ZERO) &&
             !bus.fifo_empty && (!tvalid_q || bus.m_axis_tready);
  end

  // Next-state, output stage and counters.
  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    sent_count_d = sent_count_q;
    done_d       = 1'b0;
    tdata_d      = tdata_q;
    tvalid_d     = tvalid_q;
    tlast_d      = tlast_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sent_count_d = LEN_ZERO;
          if (length != LEN_ZERO) begin
            remaining_d = length;
            state_d     = ST_STREAM;
          end else begin
            done_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_STREAM: begin
        if (load_s) begin
          tdata_d     = bus.fifo_dout;
          tvalid_d    = 1'b1;
          tlast_d     = (remaining_q == LEN_ONE);
          remaining_d = remaining_q - LEN_ONE;
        end else if (hs_s) begin
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
        end else begin
          tvalid_d = tvalid_q;
        end

        // The final word can never coincide with a load: remaining is already zero.
        if (hs_s) begin
          sent_count_d = sent_count_q + LEN_ONE;
          if (tlast_q) begin
            done_d   = 1'b1;
            state_d  = ST_IDLE;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
          end else begin
            state_d = ST_STREAM;
          end
        end else begin
          sent_count_d = sent_count_q;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset discards any word held in the output stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      remaining_q  <= LEN_ZERO;
      sent_count_q <= LEN_ZERO;
      done_q       <= 1'b0;
      tdata_q      <= {DATA_WIDTH{1'b0}};
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      sent_count_q <= sent_count_d;
      done_q       <= done_d;
      tdata_q      <= tdata_d;
      tvalid_q     <= tvalid_d;
      tlast_q      <= tlast_d;
    end
  end

  assign busy              = (state_q == ST_STREAM);
  assign done              = done_q;
  assign sent_count        = sent_count_q;
  assign bus.fifo_rd_en    = load_s;
  assign bus.m_axis_tdata  = tdata_q;
  assign bus.m_axis_tvalid = tvalid_q;
  assign bus.m_axis_tlast  = tlast_q;

endmodule

// File: tb/tb_pr_fifo_axis_reader.sv
// Bench for pr_fifo_axis_reader: behavioural FWFT FIFO, per-cycle protocol monitor,
// data scoreboard filled as words are written into the FIFO, table-driven bursts.
module tb_pr_fifo_axis_reader;
  localparam int DW = 32;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [LW-1:0] length;
  logic          busy;
  logic          done;
  logic [LW-1:0] sent_count;

  pr_fifo_axis_reader_if #(.DATA_WIDTH(DW)) bus ();

  pr_fifo_axis_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .length     (length),
    .busy       (busy),
    .done       (done),
    .sent_count (sent_count),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int len;
    int preload;
    int ready_pct;
    int feed_gap;
    int feed_words;
    bit spurious;
    int exp_sent;
    int exp_left;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];

  int            pops = 0;
  int            burst_pops = 0;
  int            hs_cnt = 0;
  int            cur_len = 0;
  int            done_seen = 0;
  bit            in_burst = 1'b0;
  bit            exp_done = 1'b0;
  logic [LW-1:0] exp_sent = '0;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;
  int            ready_pct = 100;
  int            feed_left = 0;
  int            feed_gap = 1;
  int            gap_cnt = 0;
  logic [DW-1:0] next_word = 32'h1000_0000;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_fifo();
    bus.fifo_empty = (fifo_q.size() == 0);
    bus.fifo_dout  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    drive_fifo();
  endtask

  task automatic flush_fifo();
    fifo_q.delete();
    exp_q.delete();
    feed_left = 0;
    drive_fifo();
  endtask

  // One clock cycle: monitor at the falling edge, FIFO/stimulus update just after the rising edge.
  task automatic cyc();
    bit hs;
    bit fin;
    bit rd;
    @(negedge clk);
    check("busy", 64'(busy), 64'(in_burst));
    check("done", 64'(done), 64'(exp_done));
    check("sent_count", 64'(sent_count), 64'(exp_sent));
    if (done) done_seen++;
    rd = bus.fifo_rd_en;
    check("rd_en_while_stalled", 64'(rd && bus.m_axis_tvalid && !bus.m_axis_tready), 64'd0);
    check("rd_en_while_empty", 64'(rd && (fifo_q.size() == 0)), 64'd0);
    check("rd_en_while_idle", 64'(rd && !in_burst), 64'd0);
    check("tvalid_while_idle", 64'(bus.m_axis_tvalid && !in_burst), 64'd0);
    if (prev_stall) begin
      check("stall_tvalid", 64'(bus.m_axis_tvalid), 64'd1);
      check("stall_tdata", 64'(bus.m_axis_tdata), 64'(prev_data));
      check("stall_tlast", 64'(bus.m_axis_tlast), 64'(prev_last));
    end
    hs  = bus.m_axis_tvalid && bus.m_axis_tready;
    fin = 1'b0;
    if (hs) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL hs_tdata: got %0h expected no word", bus.m_axis_tdata);
      end else begin
        check("hs_tdata", 64'(bus.m_axis_tdata), 64'(exp_q.pop_front()));
      end
      hs_cnt++;
      fin = (hs_cnt == cur_len);
      check("hs_tlast", 64'(bus.m_axis_tlast), 64'(fin));
    end
    prev_stall = bus.m_axis_tvalid && !bus.m_axis_tready;
    prev_data  = bus.m_axis_tdata;
    prev_last  = bus.m_axis_tlast;
    exp_done   = 1'b0;
    if (in_burst) begin
      if (hs) exp_sent = exp_sent + 16'd1;
      if (fin) begin
        in_burst = 1'b0;
        exp_done = 1'b1;
      end
    end else if (start) begin
      exp_sent   = '0;
      hs_cnt     = 0;
      burst_pops = 0;
      cur_len    = int'(length);
      if (length != '0) in_burst = 1'b1;
      else exp_done = 1'b1;
    end
    @(posedge clk);
    #1;
    if (rd) begin
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
      pops++;
      burst_pops++;
    end
    if (feed_left > 0) begin
      gap_cnt++;
      if (gap_cnt >= feed_gap) begin
        gap_cnt = 0;
        feed_left--;
        push_word(next_word);
        next_word = next_word + 32'd1;
      end
    end
    bus.m_axis_tready = ($urandom_range(99) < ready_pct);
    drive_fifo();
  endtask

  task automatic run_burst(input int len, input bit spurious);
    done_seen = 0;
    start     = 1'b1;
    length    = LW'(len);
    cyc();
    start = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if (done_seen != 0) break;
      if (spurious && in_burst && (i % 4 == 1)) begin
        start  = 1'b1;
        length = 16'd3;
      end else begin
        start = 1'b0;
      end
      cyc();
    end
    start = 1'b0;
    check("burst_done_seen", 64'(done_seen), 64'd1);
  endtask

  vec_t vecs[6];

  initial begin
    int pops0;
    int hs_wait;

    vecs[0] = '{len: 8,  preload: 8, ready_pct: 50,  feed_gap: 1, feed_words: 0,  spurious: 1'b0, exp_sent: 8,  exp_left: 0};
    vecs[1] = '{len: 6,  preload: 0, ready_pct: 100, feed_gap: 3, feed_words: 7,  spurious: 1'b0, exp_sent: 6,  exp_left: 1};
    vecs[2] = '{len: 0,  preload: 2, ready_pct: 100, feed_gap: 1, feed_words: 0,  spurious: 1'b0, exp_sent: 0,  exp_left: 2};
    vecs[3] = '{len: 1,  preload: 2, ready_pct: 100, feed_gap: 1, feed_words: 0,  spurious: 1'b0, exp_sent: 1,  exp_left: 1};
    vecs[4] = '{len: 5,  preload: 6, ready_pct: 60,  feed_gap: 1, feed_words: 0,  spurious: 1'b1, exp_sent: 5,  exp_left: 1};
    vecs[5] = '{len: 12, preload: 4, ready_pct: 80,  feed_gap: 2, feed_words: 10, spurious: 1'b0, exp_sent: 12, exp_left: 2};

    rst               = 1'b1;
    start             = 1'b0;
    length            = '0;
    bus.m_axis_tready = 1'b1;
    drive_fifo();

    // Reset values must appear before any clock edge.
    #3;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_sent_count", 64'(sent_count), 64'd0);
    check("rst_rd_en", 64'(bus.fifo_rd_en), 64'd0);
    check("rst_tdata", 64'(bus.m_axis_tdata), 64'd0);
    check("rst_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
    check("rst_tlast", 64'(bus.m_axis_tlast), 64'd0);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;

    // Preloaded FIFO must stay untouched until a start arrives.
    for (int i = 1; i <= 4; i++) push_word(DW'(i));
    pops0 = pops;
    repeat (5) cyc();
    check("idle_no_pops", 64'(pops - pops0), 64'd0);
    check("idle_fifo_level", 64'(fifo_q.size()), 64'd4);
    flush_fifo();

    // Basic burst with exact start-to-valid latency.
    for (int i = 0; i < 4; i++) push_word(32'hA0 + DW'(i));
    ready_pct = 100;
    pops0     = pops;
    done_seen = 0;
    start     = 1'b1;
    length    = 16'd4;
    cyc();
    start = 1'b0;
    check("basic_busy_after_start", 64'(busy), 64'd1);
    check("basic_tvalid_after_start", 64'(bus.m_axis_tvalid), 64'd0);
    check("basic_rd_en_after_start", 64'(bus.fifo_rd_en), 64'd1);
    cyc();
    check("basic_first_tvalid", 64'(bus.m_axis_tvalid), 64'd1);
    check("basic_first_tdata", 64'(bus.m_axis_tdata), 64'hA0);
    repeat (4) cyc();
    check("basic_done", 64'(done), 64'd1);
    check("basic_busy_fall", 64'(busy), 64'd0);
    check("basic_sent_count", 64'(sent_count), 64'd4);
    check("basic_pops", 64'(pops - pops0), 64'd4);
    check("basic_fifo_empty", 64'(fifo_q.size()), 64'd0);
    repeat (2) cyc();

    // Table-driven bursts.
    foreach (vecs[k]) begin
      flush_fifo();
      for (int i = 0; i < vecs[k].preload; i++) begin
        push_word(next_word);
        next_word = next_word + 32'd1;
      end
      ready_pct = vecs[k].ready_pct;
      feed_gap  = vecs[k].feed_gap;
      feed_left = vecs[k].feed_words;
      gap_cnt   = 0;
      pops0     = pops;
      run_burst(vecs[k].len, vecs[k].spurious);
      check("vec_sent_count", 64'(sent_count), 64'(vecs[k].exp_sent));
      check("vec_pops", 64'(pops - pops0), 64'(vecs[k].len));
      check("vec_words_left", 64'(fifo_q.size() + feed_left), 64'(vecs[k].exp_left));
      feed_left = 0;
      ready_pct = 100;
      repeat (3) cyc();
    end

    // Reset in the middle of a burst, then resume from the next FIFO word.
    flush_fifo();
    for (int i = 0; i < 12; i++) push_word(32'hC0 + DW'(i));
    ready_pct = 100;
    done_seen = 0;
    start     = 1'b1;
    length    = 16'd10;
    cyc();
    start   = 1'b0;
    hs_wait = 0;
    while (hs_cnt < 4 && hs_wait < 50) begin
      cyc();
      hs_wait++;
    end
    check("midrst_reached_4_handshakes", 64'(hs_cnt >= 4), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_rd_en", 64'(bus.fifo_rd_en), 64'd0);
    check("midrst_sent_count", 64'(sent_count), 64'd0);
    for (int i = 0; i < burst_pops - hs_cnt; i++) begin
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
    in_burst   = 1'b0;
    exp_done   = 1'b0;
    exp_sent   = '0;
    prev_stall = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b0;
    check("midrst_next_word_is_head", 64'(exp_q.size() != 0 && fifo_q.size() != 0 && exp_q[0] == fifo_q[0]), 64'd1);
    run_burst(2, 1'b0);
    check("postrst_sent_count", 64'(sent_count), 64'd2);
    repeat (2) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pr_fifo_axis_reader.md
# pr_fifo_axis_reader

Read-side drain engine for the PR controller's first-word-fall-through sync FIFO. On a start command it pops exactly `length` words from the FIFO's read port and presents them as an AXI4-Stream master burst, asserting TLAST on the final word. It sits between the bitstream staging FIFO and the downstream configuration stream consumer, providing full-throughput transfer with a registered output stage.

## Interface
- DATA_WIDTH, 32, width of FIFO read data and TDATA
- LEN_WIDTH, 16, width of the burst length and count fields

- clk  in  1  sole clock; all logic rising-edge
- rst  in  1  reset, asynchronous assert, active-high
- start  in  1  one-cycle command; sampled only in IDLE
- length  in  LEN_WIDTH  burst length in words; sampled with start
- busy  out  1  high in STREAM state
- done  out  1  one-cycle pulse when a burst completes
- sent_count  out  LEN_WIDTH  words accepted downstream in the current/last burst
- fifo_dout  in  DATA_WIDTH  FWFT FIFO head word, valid when fifo_empty=0
- fifo_empty  in  1  FIFO empty flag
- fifo_rd_en  out  1  pop FIFO head (combinational)
- m_axis_tdata  out  DATA_WIDTH  stream data (registered)
- m_axis_tvalid  out  1  stream valid (registered)
- m_axis_tlast  out  1  last word of burst (registered)
- m_axis_tready  in  1  downstream ready

## Operation
- States: IDLE, STREAM.
- IDLE: start=1, length≠0 → latch remaining=length, clear sent_count, go STREAM. start=1, length=0 → done pulses next cycle, stay IDLE, sent_count cleared to 0. start ignored in STREAM.
- Output register is one entry: `load = (state==STREAM) && remaining≠0 && !fifo_empty && (!m_axis_tvalid || m_axis_tready)`.
- fifo_rd_en = load. Never asserts while fifo_empty=1 or in IDLE.
- On load: tdata←fifo_dout, tvalid←1, tlast←(remaining==1), remaining←remaining−1.
- On handshake (tvalid && tready) without load: tvalid←0, tlast←0.
- Each handshake increments sent_count (wraps mod 2^LEN_WIDTH; length caps it so no wrap in practice).
- Handshake with tlast=1 → done pulses next cycle, state→IDLE, tvalid/tlast cleared.
- TDATA/TLAST held stable while tvalid=1 and tready=0 (AXI4-Stream rule); tvalid never drops without handshake.
- FIFO empty mid-burst: tvalid drops after current word accepted; resumes when FIFO refills. No timeout.
- rst asserted mid-burst: immediate return to IDLE; words already popped but not accepted are discarded; FIFO not touched.

## Timing
- Reset values: busy=0, done=0, sent_count=0, fifo_rd_en=0, m_axis_tdata=0, m_axis_tvalid=0, m_axis_tlast=0, remaining=0.
- start at edge N → busy=1 after edge N; first fifo_rd_en possible in cycle N+1; first tvalid=1 after edge N+1 (2-cycle start-to-valid latency with FIFO non-empty).
- Steady state with tready=1 and FIFO non-empty: one word per cycle, no bubbles.
- done is high for exactly one cycle, the cycle after the final handshake; busy falls in the same cycle done rises.
- A new start may be issued in the cycle done is high (state is IDLE).
- fifo_rd_en is combinational from registered state, fifo_empty and m_axis_tready; no combinational path from fifo_dout to any output.

## Test plan
- Reset: assert rst mid-cycle, all outputs 0 immediately without clock edge; release, FIFO preloaded with 0x1..0x4, no rd_en until start.
- Basic burst: FIFO holds 0xA0..0xA3, start length=4, tready=1 → tvalid from cycle N+2, data A0,A1,A2,A3 on consecutive cycles, tlast only on A3, done one cycle later, sent_count=4, FIFO left empty with exactly 4 pops.
- Backpressure: length=8, tready random 50%, FIFO preloaded → tdata/tlast stable while stalled, order preserved, 8 handshakes, rd_en never asserted while tvalid && !tready.
- Underflow gaps: length=6, FIFO fed 1 word every 3 cycles → tvalid gaps, no rd_en while fifo_empty=1, tlast on 6th word, 7th FIFO word remains unread.
- Edge lengths: start length=0 → done one cycle later, busy never high, no rd_en; start length=1 → single word with tlast=1; start pulses during STREAM ignored.
- Reset mid-burst: length=10, rst after 4 handshakes → tvalid=0, busy=0 immediately; subsequent start length=2 delivers next 2 FIFO words with correct tlast.
